// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized input, mid-bit sampling, one-cycle
// rx_valid / frame_err pulses and a busy flag.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      idx, idx_n;
  logic [7:0]      shift, shift_n;
  logic [7:0]      data_n;
  logic            valid_n, err_n;
  logic            rx_meta, rx_s, rx_prev;
  logic            fall_c;

  // Synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall_c = rx_prev & ~rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      rx_data   <= data_n;
      rx_valid  <= valid_n;
      frame_err <= err_n;
      busy      <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    data_n  = rx_data;
    valid_n = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (fall_c) state_n = START;
      end
      START: begin
        // Half a bit in, the line must still be low or it was a glitch
        if (cnt == HALF_M1) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_n          = '0;
          shift_n[idx]   = rx_s;
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 3'd1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_s) begin
            data_n  = shift;
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT SHALL have default 868 and set the clock cycles per bit period (100 MHz / 115200); the legal range SHALL be >= 4.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 rx  input  1  SHALL be the asynchronous serial line, idle high, carrying 8N1 frames LSB first.
REQ-005 rx_data  output  8  SHALL hold the last correctly framed byte.
REQ-006 rx_valid  output  1  SHALL pulse high for one cycle when rx_data updates.
REQ-007 frame_err  output  1  SHALL pulse high for one cycle when a stop bit samples low.
REQ-008 busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer (rx_s); all decisions SHALL use rx_s only.
REQ-010 FSM states SHALL be IDLE, START, DATA and STOP, with one bit counter 0..CLKS_PER_BIT-1 and one 3-bit bit index.
REQ-011 In IDLE, a falling edge (previous rx_s=1, current rx_s=0) SHALL move the FSM to START with counter=0; a constant low line SHALL NOT start a frame.
REQ-012 In START, when counter reaches CLKS_PER_BIT/2-1 (integer divide): rx_s=0 SHALL move to DATA with counter=0 and index=0; rx_s=1 SHALL be a glitch, returning to IDLE with no output pulse.
REQ-013 In DATA, when counter reaches CLKS_PER_BIT-1, rx_s SHALL be shifted into bit[index] and counter cleared; on index=7 the FSM SHALL go to STOP, otherwise index SHALL increment.
REQ-014 In STOP, when counter reaches CLKS_PER_BIT-1: rx_s=1 SHALL load rx_data and assert rx_valid on the next cycle; rx_s=0 SHALL leave rx_data unchanged and assert frame_err on the next cycle; both cases SHALL return to IDLE.
REQ-015 rx_valid and frame_err SHALL never be high in the same cycle and SHALL each last exactly one cycle.
REQ-016 rx_data SHALL be stable between rx_valid pulses.
REQ-017 Counter arithmetic SHALL use $clog2(CLKS_PER_BIT) bits, with no wrap beyond CLKS_PER_BIT-1.
REQ-018 After a frame error with the line held low (break), the FSM SHALL stay in IDLE until rx_s returns high and falls again.
REQ-019 A new falling edge arriving in the same cycle the FSM returns to IDLE SHALL be detected; back-to-back frames with one stop bit SHALL be received without loss.
REQ-020 Latency from the first rx_s low sample to rx_valid SHALL be CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles, +/-1.

Reset
REQ-021 While rst=1: state=IDLE, counter=0, index=0, synchronizer flops and edge-history flop=1, rx_data=8'h00, rx_valid=0, frame_err=0, busy=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no pulse; the first frame after release SHALL require a fresh falling edge.

Verification (CLKS_PER_BIT=16)
REQ-023 Send 8'hA5 with stop=1 -> exactly one rx_valid pulse, rx_data=8'hA5, frame_err never high, busy low after the pulse.
REQ-024 Low glitch of 4 cycles on an idle line -> FSM returns to IDLE, no rx_valid, no frame_err, rx_data unchanged.
REQ-025 Send 8'h3C with stop bit forced 0 -> one frame_err pulse, rx_data keeps its previous value, and no new frame starts while the line stays low.
REQ-026 Frames 8'h00, 8'hFF and 8'h55 back-to-back -> three rx_valid pulses in order with matching data.
REQ-027 Assert rst during bit 3 of 8'h81, release, then send 8'h42 -> no pulse for the aborted frame, rx_data=8'h42 afterward.
REQ-028 Send 8'h5A at bit period 16 +/- 3% -> rx_data=8'h5A with no frame_err.
